// File: rtl/lbp_pixel_sequencer_if.sv
// Control, strobe and result signals between the LBP sequencer and its pixel front-end / consumer.
// The master modport is the sequencer; the slave modport is the environment that drives it.
interface lbp_pixel_sequencer_if #(
    parameter int N_PD  = 12,
    parameter int CNT_W = 8
);
    logic             start_i;
    logic             cont_i;
    logic             rotinv_i;
    logic             abort_i;
    logic [CNT_W-1:0] t_rst_i;
    logic [CNT_W-1:0] t_int_i;
    logic [CNT_W-1:0] t_sh_i;
    logic [CNT_W-1:0] t_cmp_i;
    logic             cmp_i;
    logic             code_ready_i;
    logic [N_PD-1:0]  pd_a_o;
    logic [N_PD-1:0]  pd_b_o;
    logic             sh_rst_o;
    logic             sh_o;
    logic             sh_cmp_o;
    logic [N_PD-1:0]  code_o;
    logic             code_valid_o;
    logic             busy_o;
    logic             overrun_o;

    modport master (
        input  start_i, cont_i, rotinv_i, abort_i,
        input  t_rst_i, t_int_i, t_sh_i, t_cmp_i,
        input  cmp_i, code_ready_i,
        output pd_a_o, pd_b_o, sh_rst_o, sh_o, sh_cmp_o,
        output code_o, code_valid_o, busy_o, overrun_o
    );

    modport slave (
        output start_i, cont_i, rotinv_i, abort_i,
        output t_rst_i, t_int_i, t_sh_i, t_cmp_i,
        output cmp_i, code_ready_i,
        input  pd_a_o, pd_b_o, sh_rst_o, sh_o, sh_cmp_o,
        input  code_o, code_valid_o, busy_o, overrun_o
    );
endinterface

// File: rtl/lbp_pixel_sequencer.sv
// Purpose: sequences reset/integrate/sample/compare strobes over an N_PD diode ring and builds the LBP code.
// Latency: T_rst + T_int + N_PD*(T_sh + T_cmp) + 1 cycles from first RST cycle to code_valid_o (+N_PD with rotation).
// Backpressure: code_o/code_valid_o hold until code_ready_i; a newer frame overwrites and sets sticky overrun_o.
module lbp_pixel_sequencer #(
    parameter int N_PD  = 12,
    parameter int CNT_W = 8
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_n,
    lbp_pixel_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_INT, S_SAMP, S_CMP, S_ROT, S_DONE
    } state_t;

    localparam int IDX_W = (N_PD > 1) ? $clog2(N_PD) : 1;
    localparam int RW    = $clog2(N_PD + 1);
    localparam int CW    = (CNT_W > RW) ? CNT_W : RW;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PD - 1);

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cur_len;
    logic [IDX_W-1:0]  idx, idx_nxt, idx_b;
    logic [CNT_W-1:0]  t_rst_q, t_int_q, t_sh_q, t_cmp_q;
    logic              rotinv_q;
    logic              cmp_s1, cmp_s2;
    logic [N_PD-1:0]   shift, shift_nxt, cand, minv;
    logic              phase_done, start_ok, restart, load, bit_cap;

    logic [N_PD-1:0]   pd_a_d, pd_b_d, pd_a_q, pd_b_q, code_q;
    logic              sh_rst_d, sh_d, sh_cmp_d, busy_d;
    logic              sh_rst_q, sh_q, sh_cmp_q, busy_q, valid_q, overrun_q;

    // Shadow registers hold length-1 so a programmed 0 behaves as 1.
    function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    assign start_ok   = (state == S_IDLE) && bus.start_i && !bus.abort_i;
    assign restart    = (state == S_DONE) && bus.cont_i && !bus.abort_i;
    assign load       = start_ok || restart;
    assign phase_done = (cnt == cur_len);
    assign bit_cap    = (state == S_CMP) && phase_done && !bus.abort_i;

    always_comb begin
        cur_len = '0;
        unique case (state)
            S_RST:   cur_len = CW'(t_rst_q);
            S_INT:   cur_len = CW'(t_int_q);
            S_SAMP:  cur_len = CW'(t_sh_q);
            S_CMP:   cur_len = CW'(t_cmp_q);
            S_ROT:   cur_len = CW'(N_PD - 1);
            default: cur_len = '0;
        endcase
    end

    // State register
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) state <= S_IDLE;
        else           state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (bus.start_i) state_nxt = S_RST;
            S_RST:  if (phase_done)  state_nxt = S_INT;
            S_INT:  if (phase_done)  state_nxt = S_SAMP;
            S_SAMP: if (phase_done)  state_nxt = S_CMP;
            S_CMP:
                if (phase_done) begin
                    if (idx != LAST_IDX) state_nxt = S_SAMP;
                    else if (rotinv_q)   state_nxt = S_ROT;
                    else                 state_nxt = S_DONE;
                end
            S_ROT:  if (phase_done)  state_nxt = S_DONE;
            S_DONE: state_nxt = bus.cont_i ? S_RST : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (bus.abort_i) state_nxt = S_IDLE;
    end

    always_comb begin
        idx_nxt = idx;
        if (load)                         idx_nxt = '0;
        else if (bit_cap && idx != LAST_IDX) idx_nxt = idx + 1'b1;
        idx_b = (idx_nxt == LAST_IDX) ? '0 : idx_nxt + 1'b1;
    end

    always_comb begin
        shift_nxt = shift;
        if (load)         shift_nxt = '0;
        else if (bit_cap) shift_nxt[idx] = cmp_s2;
    end

    // Output logic: registered outputs are decoded from the state being entered.
    always_comb begin
        pd_a_d = '0;
        pd_b_d = '0;
        if (state_nxt == S_SAMP || state_nxt == S_CMP) begin
            pd_a_d[idx_nxt] = 1'b1;
            pd_b_d[idx_b]   = 1'b1;
        end
        sh_rst_d = (state_nxt == S_RST);
        sh_d     = (state_nxt == S_SAMP);
        sh_cmp_d = (state_nxt == S_CMP);
        busy_d   = (state_nxt != S_IDLE);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            cnt      <= '0;
            idx      <= '0;
            t_rst_q  <= '0;
            t_int_q  <= '0;
            t_sh_q   <= '0;
            t_cmp_q  <= '0;
            rotinv_q <= 1'b0;
            cmp_s1   <= 1'b0;
            cmp_s2   <= 1'b0;
            shift    <= '0;
            cand     <= '0;
            minv     <= '0;
        end else begin
            cmp_s1 <= bus.cmp_i;
            cmp_s2 <= cmp_s1;
            if (load) begin
                t_rst_q  <= len_m1(bus.t_rst_i);
                t_int_q  <= len_m1(bus.t_int_i);
                t_sh_q   <= len_m1(bus.t_sh_i);
                t_cmp_q  <= len_m1(bus.t_cmp_i);
                rotinv_q <= bus.rotinv_i;
            end
            cnt   <= (load || state_nxt != state) ? '0 : cnt + 1'b1;
            idx   <= idx_nxt;
            shift <= shift_nxt;
            // The search visits every rotation once, starting from the raw code itself.
            if (state != S_ROT && state_nxt == S_ROT) begin
                cand <= shift_nxt;
                minv <= shift_nxt;
            end else if (state == S_ROT) begin
                cand <= {cand[0], cand[N_PD-1:1]};
                if (cand < minv) minv <= cand;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            pd_a_q    <= '0;
            pd_b_q    <= '0;
            sh_rst_q  <= 1'b0;
            sh_q      <= 1'b0;
            sh_cmp_q  <= 1'b0;
            busy_q    <= 1'b0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            pd_a_q   <= pd_a_d;
            pd_b_q   <= pd_b_d;
            sh_rst_q <= sh_rst_d;
            sh_q     <= sh_d;
            sh_cmp_q <= sh_cmp_d;
            busy_q   <= busy_d;
            // Abort freezes the result side so no partial code escapes.
            if (!bus.abort_i) begin
                if (state == S_DONE) begin
                    code_q  <= rotinv_q ? minv : shift;
                    valid_q <= 1'b1;
                    if (valid_q && !bus.code_ready_i) overrun_q <= 1'b1;
                end else if (valid_q && bus.code_ready_i) begin
                    valid_q <= 1'b0;
                end
                if (start_ok) overrun_q <= 1'b0;
            end
        end
    end

    assign bus.pd_a_o       = pd_a_q;
    assign bus.pd_b_o       = pd_b_q;
    assign bus.sh_rst_o     = sh_rst_q;
    assign bus.sh_o         = sh_q;
    assign bus.sh_cmp_o     = sh_cmp_q;
    assign bus.busy_o       = busy_q;
    assign bus.code_o       = code_q;
    assign bus.code_valid_o = valid_q;
    assign bus.overrun_o    = overrun_q;
endmodule

// File: tb/tb_lbp_pixel_sequencer.sv
// Directed bench for lbp_pixel_sequencer: 12-diode ring, 8-bit phase durations.
module tb_lbp_pixel_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    logic [11:0] cmp_pat = '0;
    logic        cmp_idle = 1'b0;

    lbp_pixel_sequencer_if #(.N_PD(12), .CNT_W(8)) bus();

    lbp_pixel_sequencer #(.N_PD(12), .CNT_W(8)) dut (
        .wb_clk_i (clk),
        .wb_rst_n (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Comparator model: the diode under test returns its bit of cmp_pat.
    always @(negedge clk) begin
        logic v;
        v = cmp_idle;
        for (int j = 0; j < 12; j++) if (bus.pd_a_o[j]) v = cmp_pat[j];
        bus.cmp_i = v;
    end

    task automatic drain();
        @(negedge clk); bus.code_ready_i = 1'b1;
        @(negedge clk); bus.code_ready_i = 1'b0;
    endtask

    // Starts a frame and returns measurements taken up to the first valid.
    task automatic run_frame(input logic [7:0] tr, ti, ts, tc, input logic rot,
                             output int len, output int n_rst, output int n_p0,
                             output int viol, output bit tmo);
        int c0;
        len = -1; n_rst = 0; n_p0 = 0; viol = 0; tmo = 1'b1;
        @(negedge clk);
        bus.t_rst_i = tr; bus.t_int_i = ti; bus.t_sh_i = ts; bus.t_cmp_i = tc;
        bus.rotinv_i = rot; bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        c0 = cyc;
        for (int k = 0; k < 300; k++) begin
            if (bus.code_valid_o) begin
                len = cyc - c0; tmo = 1'b0;
                break;
            end
            if (bus.sh_rst_o) n_rst++;
            if (bus.pd_a_o[0]) n_p0++;
            if ((bus.sh_o && bus.sh_cmp_o) || (bus.sh_rst_o && (bus.sh_o || bus.sh_cmp_o)) ||
                ($countones(bus.pd_a_o) > 1) || ($countones(bus.pd_b_o) > 1) ||
                ((bus.pd_a_o != '0) != (bus.sh_o || bus.sh_cmp_o)) ||
                (bus.pd_b_o != {bus.pd_a_o[10:0], bus.pd_a_o[11]}))
                viol++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({bus.pd_a_o, bus.pd_b_o} !== '0 || {bus.sh_rst_o, bus.sh_o, bus.sh_cmp_o} !== 3'b000) begin
            errors++; $display("FAIL reset_strobes: got pd_a=%h pd_b=%h strobes=%b want 0", bus.pd_a_o, bus.pd_b_o, {bus.sh_rst_o, bus.sh_o, bus.sh_cmp_o});
        end
        checks++;
        if ({bus.code_o, bus.code_valid_o, bus.busy_o, bus.overrun_o} !== '0) begin
            errors++; $display("FAIL reset_result: got code=%h valid=%b busy=%b ovr=%b want 0", bus.code_o, bus.code_valid_o, bus.busy_o, bus.overrun_o);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b want 0", bus.busy_o); end
    endtask

    task automatic test_single_frame();
        int len, nr, np, vi; bit tmo;
        cmp_pat = 12'h500;
        run_frame(8'd2, 8'd3, 8'd1, 8'd2, 1'b0, len, nr, np, vi, tmo);
        checks++;
        if (tmo || len != 42) begin errors++; $display("FAIL single_len: got %0d (timeout=%0b) want 42", len, tmo); end
        checks++;
        if (nr != 2) begin errors++; $display("FAIL single_rst_cycles: got %0d want 2", nr); end
        checks++;
        if (np != 3) begin errors++; $display("FAIL single_pair_cycles: got %0d want 3", np); end
        checks++;
        if (vi != 0) begin errors++; $display("FAIL single_strobe_rules: got %0d violations want 0", vi); end
        checks++;
        if (bus.code_o !== 12'h500) begin errors++; $display("FAIL single_code: got %h want 500", bus.code_o); end
        checks++;
        if (bus.busy_o !== 1'b0 || bus.overrun_o !== 1'b0) begin
            errors++; $display("FAIL single_idle: busy=%b ovr=%b want 0 0", bus.busy_o, bus.overrun_o);
        end
        @(negedge clk); bus.code_ready_i = 1'b1;
        @(negedge clk); bus.code_ready_i = 1'b0;
        checks++;
        if (bus.code_valid_o !== 1'b0) begin errors++; $display("FAIL single_ready_clear: valid=%b want 0", bus.code_valid_o); end
    endtask

    task automatic test_rotation();
        int len, nr, np, vi; bit tmo;
        cmp_pat = 12'h500;
        run_frame(8'd2, 8'd3, 8'd1, 8'd2, 1'b1, len, nr, np, vi, tmo);
        checks++;
        if (tmo || len != 54) begin errors++; $display("FAIL rot_len: got %0d (timeout=%0b) want 54", len, tmo); end
        checks++;
        if (bus.code_o !== 12'h005) begin errors++; $display("FAIL rot_code: got %h want 005", bus.code_o); end
        drain();
    endtask

    task automatic test_overrun_cont();
        int len, nr, np, vi, n2; bit tmo;
        cmp_pat = 12'h500;
        bus.cont_i = 1'b1;
        run_frame(8'd2, 8'd3, 8'd1, 8'd2, 1'b0, len, nr, np, vi, tmo);
        cmp_pat = 12'h0F3;
        checks++;
        if (tmo || bus.code_o !== 12'h500 || bus.overrun_o !== 1'b0) begin
            errors++; $display("FAIL cont_first: code=%h ovr=%b timeout=%0b want 500 0 0", bus.code_o, bus.overrun_o, tmo);
        end
        checks++;
        if (bus.sh_rst_o !== 1'b1) begin errors++; $display("FAIL cont_no_gap: sh_rst=%b want 1", bus.sh_rst_o); end
        n2 = -1;
        for (int k = 0; k < 100; k++) begin
            if (bus.overrun_o) begin n2 = k; break; end
            @(negedge clk);
        end
        bus.cont_i = 1'b0;
        checks++;
        if (n2 != 42) begin errors++; $display("FAIL cont_second_len: got %0d want 42", n2); end
        checks++;
        if (bus.code_o !== 12'h0F3 || bus.code_valid_o !== 1'b1) begin
            errors++; $display("FAIL cont_second_code: code=%h valid=%b want 0f3 1", bus.code_o, bus.code_valid_o);
        end
        bus.code_ready_i = 1'b1;
        @(negedge clk); bus.code_ready_i = 1'b0;
        checks++;
        if (bus.code_valid_o !== 1'b0 || bus.overrun_o !== 1'b1) begin
            errors++; $display("FAIL ovr_sticky: valid=%b ovr=%b want 0 1", bus.code_valid_o, bus.overrun_o);
        end
        bus.abort_i = 1'b1;
        @(negedge clk); bus.abort_i = 1'b0;
        checks++;
        if (bus.busy_o !== 1'b0 || bus.overrun_o !== 1'b1) begin
            errors++; $display("FAIL ovr_abort: busy=%b ovr=%b want 0 1", bus.busy_o, bus.overrun_o);
        end
    endtask

    task automatic test_abort();
        int len, nr, np, vi; bit tmo, hit;
        cmp_pat = 12'h500;
        @(negedge clk);
        bus.t_rst_i = 8'd2; bus.t_int_i = 8'd3; bus.t_sh_i = 8'd1; bus.t_cmp_i = 8'd2;
        bus.rotinv_i = 1'b0; bus.start_i = 1'b1;
        @(negedge clk); bus.start_i = 1'b0;
        checks++;
        if (bus.overrun_o !== 1'b0) begin errors++; $display("FAIL start_clears_ovr: ovr=%b want 0", bus.overrun_o); end
        hit = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (bus.pd_a_o[5] && bus.sh_cmp_o) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL abort_reach_cmp5: got timeout want pair5 CMP"); end
        bus.abort_i = 1'b1;
        @(negedge clk); bus.abort_i = 1'b0;
        checks++;
        if (bus.busy_o !== 1'b0 || {bus.pd_a_o, bus.pd_b_o} !== '0 || {bus.sh_rst_o, bus.sh_o, bus.sh_cmp_o} !== 3'b000) begin
            errors++; $display("FAIL abort_idle: busy=%b pd_a=%h pd_b=%h strobes=%b want all 0", bus.busy_o, bus.pd_a_o, bus.pd_b_o, {bus.sh_rst_o, bus.sh_o, bus.sh_cmp_o});
        end
        checks++;
        if (bus.code_valid_o !== 1'b0 || bus.code_o !== 12'h0F3) begin
            errors++; $display("FAIL abort_result_held: valid=%b code=%h want 0 0f3", bus.code_valid_o, bus.code_o);
        end
        run_frame(8'd2, 8'd3, 8'd1, 8'd2, 1'b0, len, nr, np, vi, tmo);
        checks++;
        if (tmo || len != 42 || bus.code_o !== 12'h500) begin
            errors++; $display("FAIL abort_restart: len=%0d code=%h want 42 500", len, bus.code_o);
        end
        drain();
    endtask

    task automatic test_zero_durations();
        int len, nr, np, vi; bit tmo;
        cmp_pat = 12'hFFF; cmp_idle = 1'b1;
        run_frame(8'd0, 8'd0, 8'd0, 8'd0, 1'b0, len, nr, np, vi, tmo);
        checks++;
        if (tmo || len != 27 || nr != 1 || np != 2 || vi != 0) begin
            errors++; $display("FAIL zero_timing: len=%0d rst=%0d pair=%0d viol=%0d want 27 1 2 0", len, nr, np, vi);
        end
        checks++;
        if (bus.code_o !== 12'hFFF) begin errors++; $display("FAIL zero_code: got %h want fff", bus.code_o); end
        drain();
        run_frame(8'd1, 8'd1, 8'd1, 8'd1, 1'b0, len, nr, np, vi, tmo);
        checks++;
        if (tmo || len != 27 || nr != 1 || np != 2) begin
            errors++; $display("FAIL one_timing: len=%0d rst=%0d pair=%0d want 27 1 2", len, nr, np);
        end
        drain();
        cmp_idle = 1'b0;
    endtask

    task automatic test_async_reset();
        bit hit;
        cmp_pat = 12'h500;
        @(negedge clk);
        bus.t_rst_i = 8'd2; bus.t_int_i = 8'd3; bus.t_sh_i = 8'd1; bus.t_cmp_i = 8'd2;
        bus.start_i = 1'b1;
        @(negedge clk); bus.start_i = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (bus.sh_o) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (!hit || {bus.pd_a_o, bus.pd_b_o, bus.code_o} !== '0 ||
            {bus.sh_rst_o, bus.sh_o, bus.sh_cmp_o, bus.code_valid_o, bus.busy_o, bus.overrun_o} !== 6'b0) begin
            errors++; $display("FAIL async_reset: reached_samp=%0b pd_a=%h sh=%b busy=%b code=%h want all 0", hit, bus.pd_a_o, bus.sh_o, bus.busy_o, bus.code_o);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (bus.busy_o !== 1'b0 || bus.sh_rst_o !== 1'b0) begin
            errors++; $display("FAIL async_release_idle: busy=%b sh_rst=%b want 0 0", bus.busy_o, bus.sh_rst_o);
        end
    endtask

    initial begin
        bus.start_i = 1'b0; bus.cont_i = 1'b0; bus.rotinv_i = 1'b0; bus.abort_i = 1'b0;
        bus.t_rst_i = '0; bus.t_int_i = '0; bus.t_sh_i = '0; bus.t_cmp_i = '0;
        bus.cmp_i = 1'b0; bus.code_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_single_frame();
        test_rotation();
        test_overrun_cont();
        test_abort();
        test_zero_durations();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
